// File: rtl/pe_pkg.sv
// Shared PE definitions: default widths, psum FSM encodings and the
// round-and-saturate helper used by the partial-sum accumulator.
package pe_pkg;

    localparam int unsigned PE_DATAWIDTH  = 8;
    localparam int unsigned PE_OUTWIDTH   = 16;
    localparam int unsigned PE_FRAC_SHIFT = 4;

    // Widest accumulator the helper handles; callers sign-extend into it.
    localparam int unsigned RS_MAXW = 64;

    typedef enum logic [1:0] {
        PSUM_IDLE  = 2'b00,
        PSUM_ACC   = 2'b01,
        PSUM_ROUND = 2'b11,
        PSUM_HOLD  = 2'b10
    } psum_state_e;

    typedef struct packed {
        logic                      sat;
        logic signed [RS_MAXW-1:0] data;
    } round_sat_t;

    // Round half-up (toward +inf), drop frac_shift bits, clip to outwidth signed.
    function automatic round_sat_t round_sat(
        input logic signed [RS_MAXW-1:0] acc,
        input int unsigned               outwidth,
        input int unsigned               frac_shift
    );
        logic signed [RS_MAXW-1:0] one;
        logic signed [RS_MAXW-1:0] bias;
        logic signed [RS_MAXW-1:0] r;
        logic signed [RS_MAXW-1:0] hi;
        logic signed [RS_MAXW-1:0] lo;
        round_sat_t                res;
        one      = RS_MAXW'(1);
        bias     = one <<< (frac_shift - 1);
        r        = (acc + bias) >>> frac_shift;
        hi       = (one <<< (outwidth - 1)) - one;
        lo       = -(one <<< (outwidth - 1));
        res.sat  = 1'b0;
        res.data = r;
        if (r > hi) begin
            res.data = hi;
            res.sat  = 1'b1;
        end else if (r < lo) begin
            res.data = lo;
            res.sat  = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/psum_accum_if.sv
// Result stream from the psum accumulator toward the next PE / GLB.
interface psum_accum_if #(
    parameter int unsigned OUTWIDTH = pe_pkg::PE_OUTWIDTH
);
    logic                       out_valid;
    logic                       out_ready;
    logic signed [OUTWIDTH-1:0] out_data;
    logic                       sat;

    modport master (output out_valid, output out_data, output sat, input out_ready);
    modport slave  (input out_valid, input out_data, input sat, output out_ready);
endinterface

// File: rtl/psum_round_sat.sv
// Combinational round-and-saturate of the accumulator down to the psum width.
module psum_round_sat
    import pe_pkg::*;
#(
    parameter int unsigned ACCWIDTH   = 24,
    parameter int unsigned OUTWIDTH   = PE_OUTWIDTH,
    parameter int unsigned FRAC_SHIFT = PE_FRAC_SHIFT
) (
    input  logic signed [ACCWIDTH-1:0] acc,
    output logic signed [OUTWIDTH-1:0] out_data_c,
    output logic                       sat_c
);

    round_sat_t rs;
    logic       unused_hi;

    always_comb begin
        rs         = round_sat(RS_MAXW'(acc), OUTWIDTH, FRAC_SHIFT);
        out_data_c = rs.data[OUTWIDTH-1:0];
        sat_c      = rs.sat;
        // Upper bits are only the sign extension of the clipped value.
        unused_hi  = ^rs.data[RS_MAXW-1:OUTWIDTH];
    end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums cfg_len Booth products onto psum_in, then
// rounds, saturates and offers the result on a valid/ready stream.
module psum_accum
    import pe_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = PE_DATAWIDTH,
    parameter int unsigned ACCWIDTH   = 24,
    parameter int unsigned OUTWIDTH   = PE_OUTWIDTH,
    parameter int unsigned FRAC_SHIFT = PE_FRAC_SHIFT,
    parameter int unsigned CNTWIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CNTWIDTH-1:0]           cfg_len,
    input  logic signed [OUTWIDTH-1:0]    psum_in,
    input  logic                          prod_valid,
    input  logic signed [2*DATAWIDTH-1:0] product,
    psum_accum_if.master                  out_if,
    output logic                          busy,
    output logic                          drop
);

    psum_state_e                state;
    logic signed [ACCWIDTH-1:0] acc;
    logic [CNTWIDTH-1:0]        remain;
    logic                       out_valid_q;
    logic signed [OUTWIDTH-1:0] out_data_q;
    logic                       sat_q;
    logic signed [OUTWIDTH-1:0] rs_data_c;
    logic                       rs_sat_c;

    psum_round_sat #(
        .ACCWIDTH   (ACCWIDTH),
        .OUTWIDTH   (OUTWIDTH),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .acc        (acc),
        .out_data_c (rs_data_c),
        .sat_c      (rs_sat_c)
    );

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.sat       = sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PSUM_IDLE;
            acc         <= '0;
            remain      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            busy        <= 1'b0;
            drop        <= 1'b0;
        end else begin
            // Products only count while accumulating; anything else is discarded.
            drop <= prod_valid && (state != PSUM_ACC);
            unique case (state)
                PSUM_IDLE: begin
                    if (start) begin
                        remain <= cfg_len;
                        acc    <= ACCWIDTH'(psum_in) <<< FRAC_SHIFT;
                        busy   <= 1'b1;
                        state  <= (cfg_len == '0) ? PSUM_ROUND : PSUM_ACC;
                    end
                end
                PSUM_ACC: begin
                    if (prod_valid) begin
                        acc    <= acc + ACCWIDTH'(product);
                        remain <= remain - CNTWIDTH'(1);
                        if (remain == CNTWIDTH'(1)) begin
                            state <= PSUM_ROUND;
                        end
                    end
                end
                PSUM_ROUND: begin
                    out_data_q  <= rs_data_c;
                    sat_q       <= rs_sat_c;
                    out_valid_q <= 1'b1;
                    state       <= PSUM_HOLD;
                end
                PSUM_HOLD: begin
                    if (out_ready_accepted()) begin
                        out_valid_q <= 1'b0;
                        sat_q       <= 1'b0;
                        busy        <= 1'b0;
                        state       <= PSUM_IDLE;
                    end
                end
                default: begin
                    state <= PSUM_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    function automatic logic out_ready_accepted();
        return out_valid_q && out_if.out_ready;
    endfunction

endmodule
